// File: rtl/counter_disp_scan.sv
// counter_disp_scan
// Extends an external 4-bit counter (Qd..Qa plus ripple-carry Rc) to a 16-bit
// count. The upper 12 bits are counted locally on each synchronized Rc rising
// edge. The full count is multiplexed onto a 4-digit, active-low seven-segment
// display.
//
// Scan index (digit_e):
//   state | meaning
//   DIG0  | showing lo nibble on AN[0]
//   DIG1  | showing hi[3:0]   on AN[1]
//   DIG2  | showing hi[7:4]   on AN[2]
//   DIG3  | showing hi[11:8]  on AN[3], dp lit if ovf
module counter_disp_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Qa,
    input  logic        Qb,
    input  logic        Qc,
    input  logic        Qd,
    input  logic        Rc,
    input  logic        clr,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic [15:0] count,
    output logic        ovf
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    // input synchronizers
    logic [3:0]    q_meta_q;
    logic [3:0]    q_sync_q;
    logic          rc_meta_q;
    logic          rc_sync_q;
    logic          rc_prev_q;
    logic          rc_prev_d;
    logic [1:0]    sync_vld_q;
    logic          rc_rise;

    // upper count
    logic [11:0]   hi_q;
    logic [11:0]   hi_d;
    logic          ovf_q;
    logic          ovf_d;

    // scan timing
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          pre_wrap;
    digit_e        idx_q;
    digit_e        idx_d;

    // display outputs
    logic [3:0]    nib_sel;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic [7:0]    seg_q;
    logic [7:0]    seg_d;

    // Active-low hex decode, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Until both sync stages hold post-reset samples, the previous-Rc register
    // follows the value about to enter the sync stage. A level already high at
    // reset release is then never seen as a rising edge.
    always_comb begin
        rc_prev_d = sync_vld_q[1] ? rc_sync_q : rc_meta_q;
    end

    assign rc_rise = rc_sync_q & ~rc_prev_q;

    // Two-flop synchronizers for the nibble and Rc, plus Rc edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta_q   <= 4'h0;
            q_sync_q   <= 4'h0;
            rc_meta_q  <= 1'b0;
            rc_sync_q  <= 1'b0;
            rc_prev_q  <= 1'b0;
            sync_vld_q <= 2'b00;
        end else begin
            q_meta_q   <= {Qd, Qc, Qb, Qa};
            q_sync_q   <= q_meta_q;
            rc_meta_q  <= Rc;
            rc_sync_q  <= rc_meta_q;
            rc_prev_q  <= rc_prev_d;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // Upper count next state; clear takes priority over a pending increment
    always_comb begin
        hi_d  = hi_q;
        ovf_d = ovf_q;
        if (clr) begin
            hi_d  = 12'h000;
            ovf_d = 1'b0;
        end else if (rc_rise) begin
            hi_d = hi_q + 12'd1;
            if (hi_q == 12'hFFF) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Upper count and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= 12'h000;
            ovf_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            ovf_q <= ovf_d;
        end
    end

    assign pre_wrap = (pre_q == PRE_LAST);

    // Prescaler and digit index next state
    always_comb begin
        pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_wrap) begin
            case (idx_q)
                DIG0:    idx_d = DIG1;
                DIG1:    idx_d = DIG2;
                DIG2:    idx_d = DIG3;
                default: idx_d = DIG0;
            endcase
        end
    end

    // Scan state: prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= DIG0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // Digit select and segment decode from the current index; AN and SEGMENT
    // come from the same index so they always describe the same digit
    always_comb begin
        nib_sel = q_sync_q;
        an_d    = 4'b1110;
        case (idx_q)
            DIG0: begin
                nib_sel = q_sync_q;
                an_d    = 4'b1110;
            end
            DIG1: begin
                nib_sel = hi_q[3:0];
                an_d    = 4'b1101;
            end
            DIG2: begin
                nib_sel = hi_q[7:4];
                an_d    = 4'b1011;
            end
            default: begin
                nib_sel = hi_q[11:8];
                an_d    = 4'b0111;
            end
        endcase
        seg_d = {~((idx_q == DIG3) & ovf_q), hex7(nib_sel)};
    end

    // Registered display outputs, blank while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;
    assign count   = {hi_q, q_sync_q};
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_counter_disp_scan.sv
// Testbench for counter_disp_scan with SCAN_DIV = 4. Stimulus pushes expected
// values, each tagged with the cycle it becomes due, into a scoreboard; a
// negedge monitor pops and compares them.
module tb_counter_disp_scan;

    localparam int SD = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        Qa    = 1'b0;
    logic        Qb    = 1'b0;
    logic        Qc    = 1'b0;
    logic        Qd    = 1'b0;
    logic        Rc    = 1'b0;
    logic        clr   = 1'b0;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] count;
    logic        ovf;

    counter_disp_scan #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Qa      (Qa),
        .Qb      (Qb),
        .Qc      (Qc),
        .Qd      (Qd),
        .Rc      (Rc),
        .clr     (clr),
        .AN      (AN),
        .SEGMENT (SEGMENT),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sel;   // 0 AN, 1 SEGMENT, 2 count, 3 ovf
        logic [15:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb_q[$];
    int          cyc   = 0;
    int          rel   = 0;
    int          n_err = 0;
    int          n_chk = 0;
    logic [11:0] exp_hi  = 12'h000;
    logic        exp_ovf = 1'b0;
    logic [3:0]  exp_lo  = 4'h0;
    logic [15:0] mon_act;

    // segments lit per hex digit, active-low, g..a
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] q_vals [5] = '{4'h3, 4'h8, 4'hF, 4'hA, 4'h9};

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int due, input int sel, input logic [15:0] exp, input string tag);
        sb_t e;
        e.due = due;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // expected AN/SEGMENT for every edge in [from, to], given stable data
    task automatic push_disp(input int from, input int to, input logic [3:0] d0,
                             input logic [11:0] h, input logic ov);
        for (int t = from; t <= to; t++) begin
            int         idx;
            logic [3:0] nib;
            logic [3:0] an_e;
            logic [7:0] seg_e;
            idx = ((t - 1 - rel) / SD) % 4;
            case (idx)
                0:       nib = d0;
                1:       nib = h[3:0];
                2:       nib = h[7:4];
                default: nib = h[11:8];
            endcase
            an_e  = ~(4'b0001 << idx);
            seg_e = {!(idx == 3 && ov), seg_tbl[nib]};
            push(t, 0, {12'h000, an_e}, "an");
            push(t, 1, {8'h00, seg_e}, "seg");
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input logic [3:0] v);
        {Qd, Qc, Qb, Qa} = v;
    endtask

    task automatic pulse();
        Rc = 1'b1;
        step();
        Rc = 1'b0;
        step();
        if (exp_hi == 12'hFFF) exp_ovf = 1'b1;
        exp_hi = exp_hi + 12'd1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drain", 16'(sb_q.size()), 16'h0000);
        sb_q.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                case (sb_q[i].sel)
                    0:       mon_act = {12'h000, AN};
                    1:       mon_act = {8'h00, SEGMENT};
                    2:       mon_act = count;
                    default: mon_act = {15'h0000, ovf};
                endcase
                chk(sb_q[i].tag, mon_act, sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;

        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_an",    16'(AN),      16'h000F);
        chk("rst_seg",   16'(SEGMENT), 16'h00FF);
        chk("rst_count", count,        16'h0000);
        chk("rst_ovf",   16'(ovf),     16'h0000);

        // release: digit0 first, full rotation every 16 cycles
        @(negedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        push(rel + 1, 2, 16'h0000, "count_after_rel");
        push_disp(rel + 1, rel + 33, 4'h0, 12'h000, 1'b0);
        drain();

        // lo tracks inputs with 2-cycle latency
        foreach (q_vals[k]) begin
            c = cyc;
            set_q(q_vals[k]);
            push(c + 1, 2, {exp_hi, exp_lo}, "lo_not_early");
            exp_lo = q_vals[k];
            push(c + 2, 2, {exp_hi, exp_lo}, "lo_latency");
            push_disp(c + 3, c + 18, exp_lo, exp_hi, exp_ovf);
            drain();
        end

        // long Rc level: one increment, 3 cycles after the pin edge
        c = cyc;
        Rc = 1'b1;
        push(c + 2, 2, {exp_hi, exp_lo}, "rc_pre_inc");
        exp_hi = exp_hi + 12'd1;
        push(c + 3, 2, {exp_hi, exp_lo}, "rc_inc");
        push(c + 50, 2, {exp_hi, exp_lo}, "rc_level_once");
        push(c + 50, 3, 16'h0000, "rc_ovf_clear");
        repeat (50) step();
        Rc = 1'b0;
        push(cyc + 5, 2, {exp_hi, exp_lo}, "rc_fall_noinc");
        drain();

        // preload to 0xFFF, then wrap
        for (int i = 0; i < 4094; i++) pulse();
        push(cyc + 1, 2, {exp_hi, exp_lo}, "preload_fff");
        push(cyc + 1, 3, 16'h0000, "ovf_before_wrap");
        step();
        step();
        c = cyc;
        push(c + 2, 3, 16'h0000, "ovf_not_early");
        pulse();
        push(c + 3, 2, {exp_hi, exp_lo}, "wrap_hi");
        push(c + 3, 3, 16'(exp_ovf), "wrap_ovf");
        step();
        step();
        push(cyc + 10, 3, 16'h0001, "ovf_sticky");
        push_disp(cyc + 1, cyc + 16, exp_lo, exp_hi, exp_ovf);
        drain();

        // clr coincident with an Rc rise
        pulse();
        pulse();
        step();
        c = cyc;
        Rc = 1'b1;
        push(c + 2, 2, {exp_hi, exp_lo}, "clr_pre_hi");
        push(c + 2, 3, 16'h0001, "clr_pre_ovf");
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        Rc  = 1'b0;
        exp_hi  = 12'h000;
        exp_ovf = 1'b0;
        push(c + 3, 2, {exp_hi, exp_lo}, "clr_hi");
        push(c + 3, 3, 16'h0000, "clr_ovf");
        push(c + 6, 2, {exp_hi, exp_lo}, "clr_no_late_inc");
        repeat (4) step();
        pulse();
        push(cyc + 1, 2, {exp_hi, exp_lo}, "post_clr_inc");
        drain();

        // reset mid-scan at index 2, Rc held high across release
        t = cyc + 2;
        while (((t - rel) % 16) != 9) t++;
        push(t, 0, 16'h000B, "an_idx2_before_rst");
        while (cyc < t) step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_hi  = 12'h000;
        exp_ovf = 1'b0;
        exp_lo  = 4'h0;
        #1;
        chk("midrst_an",    16'(AN),      16'h000F);
        chk("midrst_seg",   16'(SEGMENT), 16'h00FF);
        chk("midrst_count", count,        16'h0000);
        chk("midrst_ovf",   16'(ovf),     16'h0000);
        Rc = 1'b1;
        set_q(4'h5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        exp_lo = 4'h5;
        push(rel + 1, 2, 16'h0000, "rel_count0");
        push(rel + 2, 2, 16'h0005, "rel_count_lo");
        push(rel + 12, 2, 16'h0005, "rel_rc_no_inc");
        push(rel + 12, 3, 16'h0000, "rel_ovf");
        push_disp(rel + 1, rel + 2, 4'h0, 12'h000, 1'b0);
        push_disp(rel + 3, rel + 18, 4'h5, 12'h000, 1'b0);
        drain();
        Rc = 1'b0;
        repeat (3) step();
        pulse();
        push(cyc + 1, 2, {exp_hi, exp_lo}, "rel_first_pulse");
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
